// File: rtl/axis_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_tx
// Purpose  : Turns a length-tagged packet command plus a plain valid/ready
//            payload word stream into AXI-Stream packets. It generates tkeep
//            and tlast from the byte count in the command. The output
//            register is fully registered and sends one beat per cycle within
//            a packet.
// Ports    : aclk/aresetn    - clock, asynchronous active-low reset
//            cmd_v_i/cmd_len_i/cmd_yumi_o  - packet command (length in bytes)
//            data_v_i/data_i/data_yumi_o   - payload words, byte 0 in [7:0]
//            m_axis_*        - AXI-Stream master (tvalid/tdata/tkeep/tlast/tready)
//            busy_o          - a packet is in flight or a beat is pending
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_tx #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int LEN_WIDTH            = 16
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              cmd_v_i,
    input  logic [LEN_WIDTH-1:0]              cmd_len_i,
    output logic                              cmd_yumi_o,
    input  logic                              data_v_i,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   data_i,
    output logic                              data_yumi_o,
    output logic                              m_axis_tvalid,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_S00_AXI_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic                              busy_o
);

    localparam int                   BEAT_BYTES = C_S00_AXI_DATA_WIDTH / 8;
    localparam logic [LEN_WIDTH-1:0] BEAT_LEN   = LEN_WIDTH'(BEAT_BYTES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   rem;        // bytes of the current packet not yet loaded
    logic                   out_free;
    logic                   tail_beat;
    logic [BEAT_BYTES-1:0]  tail_keep;

    // The output register can take a new beat when it is empty or its
    // current beat is handshaking this cycle.
    assign out_free    = !m_axis_tvalid || m_axis_tready;
    assign cmd_yumi_o  = (state == IDLE) && cmd_v_i;
    assign data_yumi_o = (state == SEND) && data_v_i && out_free;
    assign busy_o      = (state == SEND) || m_axis_tvalid;
    assign tail_beat   = (rem <= BEAT_LEN);

    // Byte enables for the final beat: the low 'rem' bytes are valid. This
    // gives all ones when rem equals the beat size.
    always_comb begin
        tail_keep = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            tail_keep[i] = (LEN_WIDTH'(i) < rem);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            rem           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            // A zero-length command is consumed without producing any beat.
            if (state == IDLE) begin
                if (cmd_v_i && (cmd_len_i != '0)) begin
                    rem   <= cmd_len_i;
                    state <= SEND;
                end
            end

            if (data_yumi_o) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= data_i;
                if (!tail_beat) begin
                    m_axis_tkeep <= '1;
                    m_axis_tlast <= 1'b0;
                    rem          <= rem - BEAT_LEN;
                end else begin
                    m_axis_tkeep <= tail_keep;
                    m_axis_tlast <= 1'b1;
                    state        <= IDLE;
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_packet_tx
// Purpose  : Directed self-checking bench for axis_packet_tx (32-bit data,
//            16-bit length). Inputs change on the falling edge and outputs
//            are sampled 1 time unit later, away from the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_tx;

    logic        clk;
    logic        rst_n;
    logic        cmd_v;
    logic [15:0] cmd_len;
    logic        cmd_yumi;
    logic        data_v;
    logic [31:0] data;
    logic        data_yumi;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tready;
    logic        busy;

    int checks;
    int errors;

    axis_packet_tx #(
        .C_S00_AXI_DATA_WIDTH (32),
        .LEN_WIDTH            (16)
    ) dut (
        .aclk          (clk),
        .aresetn       (rst_n),
        .cmd_v_i       (cmd_v),
        .cmd_len_i     (cmd_len),
        .cmd_yumi_o    (cmd_yumi),
        .data_v_i      (data_v),
        .data_i        (data),
        .data_yumi_o   (data_yumi),
        .m_axis_tvalid (tvalid),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast),
        .m_axis_tready (tready),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                              input logic l);
        check_eq({tag, ".tvalid"}, 64'(tvalid), 64'd1);
        check_eq({tag, ".tdata"},  64'(tdata),  64'(d));
        check_eq({tag, ".tkeep"},  64'(tkeep),  64'(k));
        check_eq({tag, ".tlast"},  64'(tlast),  64'(l));
    endtask

    // Advance to the next falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        cmd_v   = 1'b0;
        cmd_len = '0;
        data_v  = 1'b0;
        data    = '0;
        tready  = 1'b0;

        // ---------------- reset state ----------------
        cyc(); cyc(); #1;
        check_eq("rst.tvalid", 64'(tvalid), 64'd0);
        check_eq("rst.tkeep",  64'(tkeep),  64'd0);
        check_eq("rst.tlast",  64'(tlast),  64'd0);
        check_eq("rst.tdata",  64'(tdata),  64'd0);
        check_eq("rst.busy",   64'(busy),   64'd0);
        check_eq("rst.dyumi",  64'(data_yumi), 64'd0);
        check_eq("rst.cyumi",  64'(cmd_yumi),  64'd0);
        rst_n = 1'b1;

        // ---------------- single partial beat: len=3 ----------------
        cyc(); cmd_v = 1; cmd_len = 3; data_v = 1; data = 32'hAABBCCDD; tready = 1; #1;
        check_eq("t1.cyumi", 64'(cmd_yumi), 64'd1);
        check_eq("t1.dyumi_idle", 64'(data_yumi), 64'd0);
        cyc(); cmd_v = 0; #1;
        check_eq("t1.dyumi", 64'(data_yumi), 64'd1);
        check_eq("t1.cyumi_send", 64'(cmd_yumi), 64'd0);
        check_eq("t1.novalid", 64'(tvalid), 64'd0);
        cyc(); data_v = 0; #1;
        check_beat("t1.beat", 32'hAABBCCDD, 4'h7, 1'b1);
        check_eq("t1.busy", 64'(busy), 64'd1);
        cyc(); #1;
        check_eq("t1.drain", 64'(tvalid), 64'd0);
        check_eq("t1.idle_busy", 64'(busy), 64'd0);

        // ---------------- multi-beat, partial tail: len=9 ----------------
        cyc(); cmd_v = 1; cmd_len = 9; data_v = 1; data = 32'h11111111; #1;
        check_eq("t2.cyumi", 64'(cmd_yumi), 64'd1);
        cyc(); cmd_v = 0; #1;
        check_eq("t2.dyumi0", 64'(data_yumi), 64'd1);
        cyc(); data = 32'h22222222; #1;
        check_eq("t2.dyumi1", 64'(data_yumi), 64'd1);
        check_beat("t2.b0", 32'h11111111, 4'hF, 1'b0);
        cyc(); data = 32'h33333333; #1;
        check_eq("t2.dyumi2", 64'(data_yumi), 64'd1);
        check_beat("t2.b1", 32'h22222222, 4'hF, 1'b0);
        cyc(); data_v = 0; #1;
        check_eq("t2.dyumi3", 64'(data_yumi), 64'd0);
        check_beat("t2.b2", 32'h33333333, 4'h1, 1'b1);
        cyc(); #1;
        check_eq("t2.drain", 64'(tvalid), 64'd0);

        // ---------------- backpressure: len=8 ----------------
        cyc(); cmd_v = 1; cmd_len = 8; data_v = 1; data = 32'hB0B0B0B0; tready = 0; #1;
        check_eq("t3.cyumi", 64'(cmd_yumi), 64'd1);
        cyc(); cmd_v = 0; #1;
        check_eq("t3.dyumi0", 64'(data_yumi), 64'd1);
        cyc(); data = 32'hB1B1B1B1; #1;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin
                cyc(); #1;
            end
            check_eq("t3.stall_dyumi", 64'(data_yumi), 64'd0);
            check_beat("t3.hold", 32'hB0B0B0B0, 4'hF, 1'b0);
        end
        cyc(); tready = 1; #1;
        check_eq("t3.release_dyumi", 64'(data_yumi), 64'd1);
        check_beat("t3.b0", 32'hB0B0B0B0, 4'hF, 1'b0);
        cyc(); data_v = 0; #1;
        check_beat("t3.b1", 32'hB1B1B1B1, 4'hF, 1'b1);
        check_eq("t3.dyumi_end", 64'(data_yumi), 64'd0);
        cyc(); #1;
        check_eq("t3.drain", 64'(tvalid), 64'd0);

        // ---------------- zero length then exact length ----------------
        cyc(); cmd_v = 1; cmd_len = 0; #1;
        check_eq("t4.cyumi0", 64'(cmd_yumi), 64'd1);
        cyc(); cmd_len = 4; data_v = 1; data = 32'hD4D4D4D4; #1;
        check_eq("t4.cyumi1", 64'(cmd_yumi), 64'd1);
        check_eq("t4.dyumi_idle", 64'(data_yumi), 64'd0);
        check_eq("t4.nobeat", 64'(tvalid), 64'd0);
        cyc(); cmd_v = 0; #1;
        check_eq("t4.dyumi", 64'(data_yumi), 64'd1);
        check_eq("t4.nobeat2", 64'(tvalid), 64'd0);
        cyc(); data_v = 0; #1;
        check_beat("t4.beat", 32'hD4D4D4D4, 4'hF, 1'b1);
        cyc(); #1;
        check_eq("t4.drain", 64'(tvalid), 64'd0);

        // ---------------- back-to-back len=4, len=4 ----------------
        cyc(); cmd_v = 1; cmd_len = 4; data_v = 1; data = 32'hE0E0E0E0; #1;
        check_eq("t5.cyumi0", 64'(cmd_yumi), 64'd1);
        check_eq("t5.dyumi_idle0", 64'(data_yumi), 64'd0);
        cyc(); #1;
        check_eq("t5.cyumi_send", 64'(cmd_yumi), 64'd0);
        check_eq("t5.dyumi0", 64'(data_yumi), 64'd1);
        cyc(); data = 32'hE1E1E1E1; #1;
        check_eq("t5.cyumi1", 64'(cmd_yumi), 64'd1);
        check_eq("t5.dyumi_gap", 64'(data_yumi), 64'd0);
        check_beat("t5.b0", 32'hE0E0E0E0, 4'hF, 1'b1);
        cyc(); cmd_v = 0; #1;
        check_eq("t5.gap", 64'(tvalid), 64'd0);
        check_eq("t5.dyumi1", 64'(data_yumi), 64'd1);
        cyc(); data_v = 0; #1;
        check_beat("t5.b1", 32'hE1E1E1E1, 4'hF, 1'b1);
        cyc(); #1;
        check_eq("t5.drain", 64'(tvalid), 64'd0);

        // ---------------- reset mid-packet: len=16 ----------------
        cyc(); cmd_v = 1; cmd_len = 16; data_v = 1; data = 32'hF0F0F0F0; #1;
        check_eq("t6.cyumi", 64'(cmd_yumi), 64'd1);
        cyc(); cmd_v = 0; #1;
        cyc(); data = 32'hF1F1F1F1; #1;
        check_beat("t6.b0", 32'hF0F0F0F0, 4'hF, 1'b0);
        cyc(); data = 32'hF2F2F2F2; #1;
        check_beat("t6.b1", 32'hF1F1F1F1, 4'hF, 1'b0);
        #1 rst_n = 1'b0; data_v = 0;
        #1;
        check_eq("t6.async_tvalid", 64'(tvalid), 64'd0);
        check_eq("t6.async_tlast",  64'(tlast),  64'd0);
        check_eq("t6.async_busy",   64'(busy),   64'd0);
        cyc(); rst_n = 1'b1; #1;
        check_eq("t6.post_busy",   64'(busy),   64'd0);
        check_eq("t6.post_tvalid", 64'(tvalid), 64'd0);
        cyc(); cmd_v = 1; cmd_len = 4; data_v = 1; data = 32'hC0FFEE00; #1;
        check_eq("t6.cyumi_new", 64'(cmd_yumi), 64'd1);
        cyc(); cmd_v = 0; #1;
        check_eq("t6.dyumi_new", 64'(data_yumi), 64'd1);
        cyc(); data_v = 0; #1;
        check_beat("t6.new", 32'hC0FFEE00, 4'hF, 1'b1);
        cyc(); #1;
        check_eq("t6.drain", 64'(tvalid), 64'd0);
        check_eq("t6.idle_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
